// File: rtl/ysyx_040750_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_040750_hazard_unit
// Purpose  : Destination-register scoreboard for EX/MEM/WB/retired slots;
//            drives forwarding match vectors and load-use stall requests.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_040750_hazard_unit (
  input  logic       I_sys_clk,
  input  logic       I_rst,
  input  logic       I_ID_valid,
  input  logic [4:0] I_ID_rs1,
  input  logic [4:0] I_ID_rs2,
  input  logic       I_ID_rs1_used,
  input  logic       I_ID_rs2_used,
  input  logic [4:0] I_ID_rd,
  input  logic       I_ID_reg_wen,
  input  logic       I_ID_is_load,
  input  logic       I_flush,
  input  logic       I_pipe_hold,
  output logic [1:0] O_EX_stall,
  output logic [1:0] O_MEM_stall,
  output logic [1:0] O_WB_stall,
  output logic       O_EX_reg_wen,
  output logic       O_MEM_reg_wen,
  output logic       O_WB_reg_wen,
  output logic       O_load_use_stall
);

  // Producer slots
  logic       ex_valid, mem_valid, wb_valid, ret_valid;
  logic [4:0] ex_rd, mem_rd, wb_rd, ret_rd;
  logic       ex_wen, mem_wen, wb_wen, ret_wen;
  logic       ex_load, mem_load, wb_load, ret_load;

  // Consumer fields of the EX slot
  logic [4:0] ex_rs1, ex_rs2;
  logic       ex_rs1_used, ex_rs2_used;

  logic       take_id;
  logic       ex_load_producer;
  logic       mem_prod, wb_prod, ret_prod;

  assign ex_load_producer = ex_valid & ex_load & ex_wen & (ex_rd != 5'd0);

  assign O_load_use_stall = I_ID_valid & ~I_flush & ex_load_producer &
                            ((I_ID_rs1_used & (I_ID_rs1 == ex_rd)) |
                             (I_ID_rs2_used & (I_ID_rs2 == ex_rd)));

  assign take_id = I_ID_valid & ~I_flush & ~O_load_use_stall;

  assign mem_prod = mem_valid & mem_wen & (mem_rd != 5'd0);
  assign wb_prod  = wb_valid  & wb_wen  & (wb_rd  != 5'd0);
  assign ret_prod = ret_valid & ret_wen & (ret_rd != 5'd0);

  assign O_EX_reg_wen  = mem_prod;
  assign O_MEM_reg_wen = wb_prod;
  assign O_WB_reg_wen  = ret_prod;

  // Every matching distance is reported; the forwarding mux picks the nearest.
  assign O_EX_stall[1]  = ex_valid & ex_rs1_used & mem_prod & (mem_rd == ex_rs1);
  assign O_EX_stall[0]  = ex_valid & ex_rs2_used & mem_prod & (mem_rd == ex_rs2);
  assign O_MEM_stall[1] = ex_valid & ex_rs1_used & wb_prod  & (wb_rd  == ex_rs1);
  assign O_MEM_stall[0] = ex_valid & ex_rs2_used & wb_prod  & (wb_rd  == ex_rs2);
  assign O_WB_stall[1]  = ex_valid & ex_rs1_used & ret_prod & (ret_rd == ex_rs1);
  assign O_WB_stall[0]  = ex_valid & ex_rs2_used & ret_prod & (ret_rd == ex_rs2);

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      ex_valid    <= 1'b0;  ex_rd  <= 5'd0;  ex_wen  <= 1'b0;  ex_load  <= 1'b0;
      mem_valid   <= 1'b0;  mem_rd <= 5'd0;  mem_wen <= 1'b0;  mem_load <= 1'b0;
      wb_valid    <= 1'b0;  wb_rd  <= 5'd0;  wb_wen  <= 1'b0;  wb_load  <= 1'b0;
      ret_valid   <= 1'b0;  ret_rd <= 5'd0;  ret_wen <= 1'b0;  ret_load <= 1'b0;
      ex_rs1      <= 5'd0;
      ex_rs2      <= 5'd0;
      ex_rs1_used <= 1'b0;
      ex_rs2_used <= 1'b0;
    end else if (!I_pipe_hold) begin
      ret_valid <= wb_valid;   ret_rd <= wb_rd;   ret_wen <= wb_wen;   ret_load <= wb_load;
      wb_valid  <= mem_valid;  wb_rd  <= mem_rd;  wb_wen  <= mem_wen;  wb_load  <= mem_load;
      mem_valid <= ex_valid;   mem_rd <= ex_rd;   mem_wen <= ex_wen;   mem_load <= ex_load;
      if (take_id) begin
        ex_valid    <= 1'b1;
        ex_rd       <= I_ID_rd;
        ex_wen      <= I_ID_reg_wen;
        ex_load     <= I_ID_is_load;
        ex_rs1      <= I_ID_rs1;
        ex_rs2      <= I_ID_rs2;
        ex_rs1_used <= I_ID_rs1_used;
        ex_rs2_used <= I_ID_rs2_used;
      end else begin
        ex_valid    <= 1'b0;
        ex_rd       <= 5'd0;
        ex_wen      <= 1'b0;
        ex_load     <= 1'b0;
        ex_rs1      <= 5'd0;
        ex_rs2      <= 5'd0;
        ex_rs1_used <= 1'b0;
        ex_rs2_used <= 1'b0;
      end
    end
  end

  // Load flag is carried down the pipe for visibility; only the EX copy drives logic.
  logic unused_load_bits;
  assign unused_load_bits = mem_load ^ wb_load ^ ret_load;

endmodule
`default_nettype wire
